// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined, handshaked ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_NOT = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned FLG_ZERO  = 0;
  localparam int unsigned FLG_CARRY = 1;
  localparam int unsigned FLG_OVF   = 2;
  localparam int unsigned FLG_DZ    = 3;
  localparam int unsigned FLG_W     = 4;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// The first bit is resolved in the start cycle so done pulses WIDTH-1 cycles later.
module alu_div_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, dvsr_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  logic [WIDTH-1:0] src_rem, src_quo, src_dvsr, rem_n, quo_n;
  logic [WIDTH:0]   trial;
  logic             qbit;

  // One restoring step on either fresh operands (start) or the running state
  always_comb begin
    src_rem  = start ? '0       : rem_q;
    src_quo  = start ? dividend : quotient;
    src_dvsr = start ? divisor  : dvsr_q;
    trial    = {src_rem, src_quo[WIDTH-1]};
    qbit     = 1'b0;
    rem_n    = trial[WIDTH-1:0];
    if (trial >= {1'b0, src_dvsr}) begin
      qbit  = 1'b1;
      rem_n = WIDTH'(trial - {1'b0, src_dvsr});
    end
    quo_n = {src_quo[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      dvsr_q   <= '0;
      quotient <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q    <= rem_n;
        quotient <= quo_n;
        dvsr_q   <= src_dvsr;
        cnt_q    <= CW'(WIDTH - 1);
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        rem_q    <= rem_n;
        quotient <= quo_n;
        cnt_q    <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit ALU: single-cycle ops plus an iterative divider,
// registered result/flags held until the consumer takes them.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  state_t state, state_n;

  logic [WIDTH-1:0]   result_n, alu_res, div_q;
  logic [FLG_W-1:0]   flags_n, alu_flg;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic               div_start, div_done, div_run;

  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign out_valid = (state == HOLD);
  assign div_run   = (opcode_t'(opcode) == OP_DIV) && (b != '0);

  // Single-cycle datapath; the OP_DIV arm only covers divide-by-zero
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    prod    = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    alu_res = '0;
    alu_flg = '0;
    case (opcode_t'(opcode))
      OP_ADD: begin
        alu_res            = sum[WIDTH-1:0];
        alu_flg[FLG_CARRY] = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res            = diff[WIDTH-1:0];
        alu_flg[FLG_CARRY] = diff[WIDTH];
      end
      OP_MUL: begin
        alu_res          = prod[WIDTH-1:0];
        alu_flg[FLG_OVF] = (prod[2*WIDTH-1:WIDTH] != '0);
      end
      OP_DIV: begin
        alu_res         = '1;
        alu_flg[FLG_DZ] = 1'b1;
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      default: alu_res = '0;
    endcase
    alu_flg[FLG_ZERO] = (alu_res == '0);
  end

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (a),
    .divisor  (b),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      flags  <= '0;
    end else begin
      state  <= state_n;
      result <= result_n;
      flags  <= flags_n;
    end
  end

  // Next state; an accept in IDLE or a consumed HOLD overrides the per-state move
  always_comb begin
    state_n   = state;
    result_n  = result;
    flags_n   = flags;
    div_start = 1'b0;
    case (state)
      IDLE: state_n = IDLE;
      DIV: begin
        if (div_done) begin
          state_n           = HOLD;
          result_n          = div_q;
          flags_n           = '0;
          flags_n[FLG_ZERO] = (div_q == '0);
        end
      end
      HOLD:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (in_valid && in_ready) begin
      if (div_run) begin
        state_n   = DIV;
        div_start = 1'b1;
      end else begin
        state_n  = HOLD;
        result_n = alu_res;
        flags_n  = alu_flg;
      end
    end
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the team's 3-bit combinational ALU.
- Same 8-opcode map, widened to WIDTH bits, with a registered result and status flags.
- Division is iterative and multi-cycle; divide-by-zero is reported as a flag instead of a high-Z result.
- Sits between an operand-issuing controller and a result consumer; valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8: operand and result width in bits (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- opcode  input  3  operation select.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- flags  output  4  {dz, ovf, carry, zero}.

Behaviour:
- Single clock, clk. Reset is asynchronous, active-low (rst_n); the block is reset while rst_n=0.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, flags=0. Divider state is cleared.
- Reset mid-division or while in HOLD aborts the operation. Nothing is emitted after reset release.
- An operation is accepted when in_valid && in_ready. a, b and opcode are captured in that cycle. Inputs are don't-care otherwise.
- Opcodes (all results truncated to WIDTH bits):
  - 000: a+b. carry = bit WIDTH of the sum.
  - 001: a-b. carry = borrow (a<b).
  - 010: a*b, low WIDTH bits. ovf = high WIDTH bits of the full product nonzero.
  - 011: a/b, unsigned quotient. The remainder is discarded.
  - 100: a&b.
  - 101: a|b.
  - 110: a^b.
  - 111: ~a (bitwise NOT).
- Flag rules:
  - zero = (result==0) for every opcode.
  - carry is 0 except for opcodes 000 and 001.
  - ovf is 0 except for opcode 010.
  - dz is 0 except for opcode 011.
- Divide by zero (opcode 011, b==0):
  - result = all ones, dz=1.
  - Completes in 1 cycle, like a non-divide op. The divider is not started.
- State machine:
  - IDLE: in_ready=1. On accept of a non-divide op, or a divide with b==0 → HOLD, with result/flags registered. On accept of a divide with b≠0 → DIV.
  - DIV: in_ready=0. Restoring divider, one quotient bit per cycle, MSB first. After exactly WIDTH cycles → HOLD with the quotient.
  - HOLD: out_valid=1. result and flags are stable until out_ready=1. If out_ready=0, stay in HOLD.
  - Leaving HOLD: on out_ready=1, if in_valid=1 a new op is accepted in the same cycle (back-to-back); otherwise → IDLE.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This is a combinational path from out_ready.
- Latency from accept to out_valid:
  - Non-divide ops and divide-by-zero: 1 cycle.
  - Divide: WIDTH+1 cycles.
- Throughput: one non-divide op per cycle while out_ready is held at 1.
- out_valid drops the cycle after the result is consumed, unless a new result was produced back-to-back.

Decomposition:
- Package alu_pkg holds:
  - opcode_t enum: OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_NOT.
  - state_t enum: IDLE, DIV, HOLD.
  - Flag bit-index constants: FLG_ZERO=0, FLG_CARRY=1, FLG_OVF=2, FLG_DZ=3.
- One sub-module, alu_div_iter (parameter WIDTH):
  - Inputs: start, dividend, divisor.
  - Outputs: done, quotient.
  - Shared clk/rst_n; it is the sequential restoring divider.
- Top level contains the FSM, the combinational single-cycle datapath, and the output registers.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles, release. Required: out_valid=0, in_ready=1, result=0, flags=0. Assert rst_n=0 asynchronously mid-cycle; outputs clear without waiting for a clock edge.
- Add overflow (WIDTH=8): a=200, b=100, op=000 with out_ready=1. Required one cycle later: result=44, carry=1, zero=0.
- Subtract to zero: a=5, b=5, op=001 → result=0, zero=1, carry=0. Then a=3, b=5, op=001 → result=254, carry=1.
- Multiply overflow: a=20, b=20, op=010 → result=144, ovf=1. Then a=3, b=4 → result=12, ovf=0.
- Divide: a=200, b=7, op=011 → in_ready=0 for 8 cycles; out_valid is asserted 9 cycles after accept with result=28. Divide by zero: a=9, b=0 → result=255, dz=1, 1-cycle latency.
- Back-pressure and back-to-back:
  - Issue AND (0xF0 & 0x3C) with out_ready=0 for 4 cycles. Required: result=0x30 held and in_ready=0 throughout.
  - Then raise out_ready with in_valid=1 carrying XOR (0xFF ^ 0x0F). Required: accepted in the same cycle, and the next cycle shows result=0xF0 with out_valid=1.
